// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types and constants.
package rv32i_types;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DISCARD
  } if_state_t;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0060;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats load, otherwise hold.
module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] pc_d,
  input  logic [31:0] instr_d,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] instr
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= NOP_INSTR;
    end else if (flush) begin
      // pc is left as-is on flush; it is meaningless while valid is low
      valid <= 1'b0;
      instr <= NOP_INSTR;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= pc_d;
      instr <= instr_d;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC, hold-until-response imem handshake, skid buffer, IF/ID.
module if_stage
  import rv32i_types::*;
#(
  parameter logic [31:0] PC_RESET  = PC_RESET_DEFAULT,
  parameter logic [31:0] NOP_INSTR = rv32i_types::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_address,
  output logic        imem_read,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        valid_id,
  output logic [31:0] pc_id,
  output logic [31:0] instr_id,
  output logic [6:0]  opcode_id,
  output logic [2:0]  funct3_id,
  output logic [6:0]  funct7_id,
  output logic [4:0]  rd_id,
  output logic [4:0]  rs1_id,
  output logic [4:0]  rs2_id
);

  if_state_t   state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] tgt, tgt_next;
  logic        buf_valid;
  logic [31:0] buf_pc, buf_instr;
  logic        buf_set, buf_clr;
  logic        reg_load, reg_flush;
  logic [31:0] ld_pc, ld_instr;

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH: begin
        if (redirect)                state_next = imem_resp ? FETCH : DISCARD;
        else if (imem_resp && stall) state_next = HOLD;
      end
      HOLD:    if (redirect || !stall) state_next = FETCH;
      DISCARD: if (imem_resp)          state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  always_comb begin
    imem_read = (state != HOLD);
    reg_load  = 1'b0;
    reg_flush = 1'b0;
    ld_pc     = pc;
    ld_instr  = imem_rdata;
    pc_next   = pc;
    tgt_next  = tgt;
    buf_set   = 1'b0;
    buf_clr   = 1'b0;
    case (state)
      FETCH: begin
        if (redirect) begin
          reg_flush = 1'b1;
          if (imem_resp) pc_next  = redirect_pc;
          else           tgt_next = redirect_pc;
        end else if (imem_resp && stall) begin
          buf_set = 1'b1;
        end else if (imem_resp) begin
          reg_load = 1'b1;
          pc_next  = pc + 32'd4;
        end else if (!stall) begin
          reg_flush = 1'b1;
        end
      end
      HOLD: begin
        if (redirect) begin
          reg_flush = 1'b1;
          buf_clr   = 1'b1;
          pc_next   = redirect_pc;
        end else if (!stall) begin
          reg_load = 1'b1;
          buf_clr  = 1'b1;
          ld_pc    = buf_pc;
          ld_instr = buf_instr;
          pc_next  = pc + 32'd4;
        end
      end
      DISCARD: begin
        // the stale response is swallowed; a same-cycle redirect overrides tgt
        reg_flush = 1'b1;
        if (imem_resp)     pc_next  = redirect ? redirect_pc : tgt;
        else if (redirect) tgt_next = redirect_pc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= PC_RESET;
      tgt       <= '0;
      buf_valid <= 1'b0;
      buf_pc    <= '0;
      buf_instr <= '0;
    end else begin
      pc  <= pc_next;
      tgt <= tgt_next;
      if (buf_set) begin
        buf_valid <= 1'b1;
        buf_pc    <= pc;
        buf_instr <= imem_rdata;
      end else if (buf_clr) begin
        buf_valid <= 1'b0;
      end
    end
  end

  assign imem_address = pc;

  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .load    (reg_load),
    .flush   (reg_flush),
    .pc_d    (ld_pc),
    .instr_d (ld_instr),
    .valid   (valid_id),
    .pc      (pc_id),
    .instr   (instr_id)
  );

  assign opcode_id = instr_id[6:0];
  assign funct3_id = instr_id[14:12];
  assign funct7_id = instr_id[31:25];
  assign rd_id     = instr_id[11:7];
  assign rs1_id    = instr_id[19:15];
  assign rs2_id    = instr_id[24:20];

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: streaming, stall/skid, redirects, wrap, reset.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_address;
  logic        imem_read;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        valid_id;
  logic [31:0] pc_id;
  logic [31:0] instr_id;
  logic [6:0]  opcode_id;
  logic [2:0]  funct3_id;
  logic [6:0]  funct7_id;
  logic [4:0]  rd_id, rs1_id, rs2_id;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  if_stage #(.PC_RESET(32'h0000_0060), .NOP_INSTR(32'h0000_0013)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_address (imem_address),
    .imem_read    (imem_read),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .valid_id     (valid_id),
    .pc_id        (pc_id),
    .instr_id     (instr_id),
    .opcode_id    (opcode_id),
    .funct3_id    (funct3_id),
    .funct7_id    (funct7_id),
    .rd_id        (rd_id),
    .rs1_id       (rs1_id),
    .rs2_id       (rs2_id)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // drive one cycle of inputs, then sample 1ns after the rising edge
  task automatic cyc(input logic resp, input logic [31:0] rdata, input logic stl,
                     input logic redir, input logic [31:0] rpc);
    imem_resp   = resp;
    imem_rdata  = rdata;
    stall       = stl;
    redirect    = redir;
    redirect_pc = rpc;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_id(input string tag, input logic v, input logic [31:0] p, input logic [31:0] i);
    chk({tag, ".valid"}, {31'd0, valid_id}, {31'd0, v});
    if (v) chk({tag, ".pc"}, pc_id, p);
    chk({tag, ".instr"}, instr_id, i);
  endtask

  task automatic chk_mem(input string tag, input logic rd, input logic [31:0] a);
    chk({tag, ".read"}, {31'd0, imem_read}, {31'd0, rd});
    chk({tag, ".addr"}, imem_address, a);
  endtask

  initial begin
    rst = 1'b1; imem_resp = 1'b0; imem_rdata = '0;
    stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst.valid", {31'd0, valid_id}, 32'd0);
    chk("rst.pc_id", pc_id, 32'h0);
    chk("rst.instr", instr_id, 32'h13);
    chk_mem("rst", 1'b1, 32'h60);
    rst = 1'b0;

    // streaming, one response per cycle
    cyc(1'b1, 32'h0000_0013, 1'b0, 1'b0, '0);
    chk_id("a1", 1'b1, 32'h60, 32'h0000_0013);
    cyc(1'b1, 32'h40B5_0533, 1'b0, 1'b0, '0);
    chk_id("a2", 1'b1, 32'h64, 32'h40B5_0533);
    chk("a2.opcode", {25'd0, opcode_id}, 32'h33);
    chk("a2.funct7", {25'd0, funct7_id}, 32'h20);
    chk("a2.rd",     {27'd0, rd_id},     32'd10);
    chk("a2.rs1",    {27'd0, rs1_id},    32'd10);
    chk("a2.rs2",    {27'd0, rs2_id},    32'd11);
    cyc(1'b1, 32'h00A5_F633, 1'b0, 1'b0, '0);
    chk_id("a3", 1'b1, 32'h68, 32'h00A5_F633);
    chk("a3.funct3", {29'd0, funct3_id}, 32'd7);
    chk("a3.rd",     {27'd0, rd_id},     32'd12);
    chk_mem("a3", 1'b1, 32'h6C);

    // response under stall goes to skid buffer; release delivers it
    cyc(1'b1, 32'h00C0_0093, 1'b1, 1'b0, '0);
    chk_id("b1", 1'b1, 32'h68, 32'h00A5_F633);
    chk_mem("b1", 1'b0, 32'h6C);
    cyc(1'b0, '0, 1'b1, 1'b0, '0);
    cyc(1'b0, '0, 1'b1, 1'b0, '0);
    chk_id("b3", 1'b1, 32'h68, 32'h00A5_F633);
    chk("b3.read", {31'd0, imem_read}, 32'd0);
    cyc(1'b0, '0, 1'b0, 1'b0, '0);
    chk_id("b4", 1'b1, 32'h6C, 32'h00C0_0093);
    chk_mem("b4", 1'b1, 32'h70);
    cyc(1'b0, '0, 1'b0, 1'b0, '0);
    chk_id("bubble", 1'b0, '0, 32'h13);
    chk_mem("bubble", 1'b1, 32'h70);

    // redirect while request outstanding -> DISCARD
    cyc(1'b0, '0, 1'b0, 1'b1, 32'h200);
    chk_mem("c1", 1'b1, 32'h70);
    cyc(1'b0, '0, 1'b0, 1'b0, '0);
    chk_mem("c2", 1'b1, 32'h70);
    cyc(1'b1, 32'hDEAD_0013, 1'b0, 1'b0, '0);
    chk_id("c3", 1'b0, '0, 32'h13);
    chk_mem("c3", 1'b1, 32'h200);
    cyc(1'b1, 32'h0010_0093, 1'b0, 1'b0, '0);
    chk_id("c4", 1'b1, 32'h200, 32'h0010_0093);

    // redirect + resp + stall in FETCH: redirect wins, response dropped
    cyc(1'b1, 32'hBAD0_0013, 1'b1, 1'b1, 32'h200);
    chk_id("d1", 1'b0, '0, 32'h13);
    chk_mem("d1", 1'b1, 32'h200);

    // two redirects during DISCARD, latest wins
    cyc(1'b0, '0, 1'b0, 1'b1, 32'h300);
    chk_mem("e1", 1'b1, 32'h200);
    cyc(1'b0, '0, 1'b0, 1'b1, 32'h400);
    chk_mem("e2", 1'b1, 32'h200);
    cyc(1'b1, 32'hBAD1_0013, 1'b0, 1'b0, '0);
    chk_mem("e3", 1'b1, 32'h400);
    chk_id("e3", 1'b0, '0, 32'h13);
    cyc(1'b1, 32'h0000_0013, 1'b0, 1'b0, '0);
    chk_id("e4", 1'b1, 32'h400, 32'h13);
    // redirect coincident with stale response in DISCARD
    cyc(1'b0, '0, 1'b0, 1'b1, 32'h500);
    chk_mem("e5", 1'b1, 32'h404);
    cyc(1'b1, 32'hBAD2_0013, 1'b0, 1'b1, 32'h600);
    chk_mem("e6", 1'b1, 32'h600);

    // PC wrap
    cyc(1'b1, 32'hBAD3_0013, 1'b0, 1'b1, 32'hFFFF_FFFC);
    chk_mem("f1", 1'b1, 32'hFFFF_FFFC);
    cyc(1'b1, 32'h0000_0013, 1'b0, 1'b0, '0);
    chk_id("f2", 1'b1, 32'hFFFF_FFFC, 32'h13);
    chk_mem("f2", 1'b1, 32'h0);

    // redirect out of HOLD
    cyc(1'b1, 32'h1111_1113, 1'b1, 1'b0, '0);
    chk_mem("g1", 1'b0, 32'h0);
    cyc(1'b0, '0, 1'b1, 1'b1, 32'h100);
    chk_id("g2", 1'b0, '0, 32'h13);
    chk_mem("g2", 1'b1, 32'h100);

    // reset while stalled in HOLD
    cyc(1'b1, 32'h40B5_0533, 1'b0, 1'b0, '0);
    chk_id("h0", 1'b1, 32'h100, 32'h40B5_0533);
    cyc(1'b1, 32'h2222_2213, 1'b1, 1'b0, '0);
    chk_mem("h1", 1'b0, 32'h104);
    rst = 1'b1;
    cyc(1'b0, '0, 1'b1, 1'b0, '0);
    chk("h2.valid", {31'd0, valid_id}, 32'd0);
    chk("h2.pc_id", pc_id, 32'h0);
    chk("h2.instr", instr_id, 32'h13);
    chk_mem("h2", 1'b1, 32'h60);
    rst = 1'b0;
    cyc(1'b1, 32'h0010_0093, 1'b0, 1'b0, '0);
    chk_id("h3", 1'b1, 32'h60, 32'h0010_0093);
    chk_mem("h3", 1'b1, 32'h64);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
